// File: rtl/fft_bitrev_reorder.sv
// ----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Purpose:
//   Output reorder stage that sits directly after the 3-stage radix-2 FFT
//   pipeline. Complete N-point frames arrive in bit-reversed order and leave
//   in natural order. A ping-pong pair of register banks lets one frame be
//   written while the previous one is read, so the block sustains one sample
//   per cycle in both directions. Sample contents ({re, im}) pass through
//   untouched.
//
// Parameters:
//   DATA_W  sample width (default 50 = {re[24:0], im[24:0]})
//   LOG2N   log2 of the frame length, N = 2**LOG2N (default 3, N = 8)
//
// Ports:
//   clk_i     in   1       single clock, rising edge
//   rst_i     in   1       asynchronous, active-high reset
//   signal_i  in   DATA_W  input sample, bit-reversed frame order
//   valid_i   in   1       signal_i valid
//   ready_o   out  1       block can accept a sample this cycle
//   signal_o  out  DATA_W  output sample, natural order
//   valid_o   out  1       signal_o valid
//   ready_i   in   1       downstream accepts signal_o this cycle
//   last_o    out  1       final sample (index N-1) of an output frame
//
// Configuration macro:
//   FFT_REORDER_LAST_EN  when defined, last_o = valid_o && (rcnt == N-1);
//                        when undefined, last_o is tied to 0.
// ----------------------------------------------------------------------------
module fft_bitrev_reorder #(
  parameter int DATA_W = 50,
  parameter int LOG2N  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] signal_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] signal_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  localparam int N = 2 ** LOG2N;

  // Index of the final sample in a frame, sized to match the counters.
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE_IDX  = LOG2N'(1);

  // Each bank is either being filled (EMPTY) or holding a complete frame
  // waiting to be read out (FULL).
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bankState_t;

  // Reverse the LOG2N bits of a frame index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    rev = '0;
    for (int b = 0; b < LOG2N; b++) begin
      rev[LOG2N-1-b] = idx[b];
    end
    return rev;
  endfunction

  // Storage: two banks of N samples each. Not reset; contents are only
  // observable while the owning bank is FULL.
  logic [DATA_W-1:0] mem_q [2][N];

  bankState_t        bankState_q [2];
  bankState_t        bankState_d [2];

  logic              wBank_q, wBank_d;
  logic [LOG2N-1:0]  wCnt_q,  wCnt_d;
  logic              rBank_q, rBank_d;
  logic [LOG2N-1:0]  rCnt_q,  rCnt_d;

  logic              accept;
  logic              xfer;
  logic              wLast;
  logic              rLast;

  // Handshake decode. ready_o depends only on registered state, so there is
  // no combinational path from ready_i back upstream.
  always_comb begin
    ready_o  = (bankState_q[wBank_q] == BANK_EMPTY);
    valid_o  = (bankState_q[rBank_q] == BANK_FULL);
    signal_o = mem_q[rBank_q][rCnt_q];
    accept   = valid_i && ready_o;
    xfer     = valid_o && ready_i;
    wLast    = accept && (wCnt_q == LAST_IDX);
    rLast    = xfer && (rCnt_q == LAST_IDX);
  end

  // Frame-end marker. When the feature is disabled the port is a constant.
`ifdef FFT_REORDER_LAST_EN
  assign last_o = valid_o && (rCnt_q == LAST_IDX);
`else
  assign last_o = 1'b0;
`endif

  // Next-state for the write side: the counter walks 0..N-1 on every accepted
  // sample and the write bank flips once a frame is complete.
  always_comb begin
    wCnt_d  = wCnt_q;
    wBank_d = wBank_q;
    if (accept) begin
      wCnt_d = wCnt_q + ONE_IDX;
    end
    if (wLast) begin
      wBank_d = ~wBank_q;
    end
  end

  // Next-state for the read side: same walk on every transfer, flipping to
  // the other bank when the last natural-order sample leaves.
  always_comb begin
    rCnt_d  = rCnt_q;
    rBank_d = rBank_q;
    if (xfer) begin
      rCnt_d = rCnt_q + ONE_IDX;
    end
    if (rLast) begin
      rBank_d = ~rBank_q;
    end
  end

  // Per-bank state transitions. A write completion and a read completion can
  // land on the same edge; they always target different banks, so both
  // updates simply apply.
  always_comb begin
    bankState_d[0] = bankState_q[0];
    bankState_d[1] = bankState_q[1];
    if (wLast) begin
      bankState_d[wBank_q] = BANK_FULL;
    end
    if (rLast) begin
      bankState_d[rBank_q] = BANK_EMPTY;
    end
  end

  // Control registers. An asynchronous reset discards any partial frame and
  // any pending full banks at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wBank_q        <= 1'b0;
      wCnt_q         <= '0;
      rBank_q        <= 1'b0;
      rCnt_q         <= '0;
      bankState_q[0] <= BANK_EMPTY;
      bankState_q[1] <= BANK_EMPTY;
    end else begin
      wBank_q        <= wBank_d;
      wCnt_q         <= wCnt_d;
      rBank_q        <= rBank_d;
      rCnt_q         <= rCnt_d;
      bankState_q[0] <= bankState_d[0];
      bankState_q[1] <= bankState_d[1];
    end
  end

  // Sample storage. Writing to the bit-reversed slot means the read side can
  // simply walk addresses in natural order.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wBank_q][bitrev(wCnt_q)] <= signal_i;
    end
  end

  // Structural invariants: the write side never targets the bank being read
  // while that bank holds a frame, and a full bank is never written.
  property pNoWriteIntoFull;
    @(posedge clk_i) disable iff (rst_i)
      accept |-> (bankState_q[wBank_q] == BANK_EMPTY);
  endproperty
  assert property (pNoWriteIntoFull);

  property pDistinctBanksWhenBusy;
    @(posedge clk_i) disable iff (rst_i)
      (wLast && rLast) |-> (wBank_q != rBank_q);
  endproperty
  assert property (pDistinctBanksWhenBusy);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Self-checking bench for fft_bitrev_reorder. A frame-level reference keeps
// the currently filling input frame and a queue of natural-order output
// samples; readiness, validity, data and the frame-end marker are all derived
// from those queues every cycle.
// ----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

  localparam int DATA_W = 50;
  localparam int LOG2N  = 3;
  localparam int N      = 2 ** LOG2N;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] signal_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] signal_o;
  logic              valid_o;
  logic              ready_i;
  logic              last_o;

  int checkCount;
  int errorCount;

  // Reference state: samples of the frame currently being filled, and the
  // natural-order samples of completed frames not yet read out.
  logic [DATA_W-1:0] partQ [$];
  logic [DATA_W-1:0] outQ  [$];

  fft_bitrev_reorder #(
    .DATA_W(DATA_W),
    .LOG2N (LOG2N)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .signal_i(signal_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .signal_o(signal_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reverse the low LOG2N bits of an index using plain arithmetic.
  function automatic int bitrevIdx(input int x);
    int r;
    r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + ((x >> b) % 2);
    end
    return r;
  endfunction

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Compare DUT outputs with the reference, then advance the reference by
  // whatever handshakes complete on the coming clock edge.
  task automatic checkAndAdvance();
    logic expValid, expReady, expLast, doXfer, doAcc;
    expValid = (outQ.size() > 0);
    expReady = (outQ.size() <= N);
`ifdef FFT_REORDER_LAST_EN
    expLast  = expValid && ((outQ.size() % N) == 1);
`else
    expLast  = 1'b0;
`endif
    checkOutput("ready_o", 64'(ready_o), 64'(expReady));
    checkOutput("valid_o", 64'(valid_o), 64'(expValid));
    checkOutput("last_o",  64'(last_o),  64'(expLast));
    if (expValid) begin
      checkOutput("signal_o", 64'(signal_o), 64'(outQ[0]));
    end
    doXfer = expValid && ready_i;
    doAcc  = valid_i && expReady;
    if (doXfer) begin
      void'(outQ.pop_front());
    end
    if (doAcc) begin
      partQ.push_back(signal_i);
      if (partQ.size() == N) begin
        for (int j = 0; j < N; j++) begin
          outQ.push_back(partQ[bitrevIdx(j)]);
        end
        partQ.delete();
      end
    end
  endtask

  // Run a number of cycles with random inputs; validPct/readyPct give the
  // percentage chance of valid_i / ready_i being high in each cycle.
  task automatic applyStimulus(input int cycles, input int validPct, input int readyPct);
    logic [63:0] raw;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      raw      = {$urandom, $urandom};
      signal_i = raw[DATA_W-1:0];
      valid_i  = ($urandom_range(99) < validPct);
      ready_i  = ($urandom_range(99) < readyPct);
      @(negedge clk);
      checkAndAdvance();
    end
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must return
  // to idle immediately, before any clock edge.
  task automatic applyReset();
    #1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst     = 1'b1;
    #1;
    checkOutput("rst_valid_o", 64'(valid_o), 64'd0);
    checkOutput("rst_ready_o", 64'(ready_o), 64'd1);
    checkOutput("rst_last_o",  64'(last_o),  64'd0);
    partQ.delete();
    outQ.delete();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst        = 1'b1;
    signal_i   = '0;
    valid_i    = 1'b0;
    ready_i    = 1'b0;

    // Reset state.
    #2;
    checkOutput("init_valid_o", 64'(valid_o), 64'd0);
    checkOutput("init_ready_o", 64'(ready_o), 64'd1);
    checkOutput("init_last_o",  64'(last_o),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single frame, then read it out.
    applyStimulus(8, 100, 0);
    applyStimulus(12, 0, 100);

    // Three back-to-back frames with a free-flowing output; includes the
    // cycle where one bank completes writing while the other completes reading.
    applyStimulus(24, 100, 100);
    applyStimulus(12, 0, 100);

    // Backpressure: two frames fill both banks, then drain.
    applyStimulus(20, 100, 0);
    applyStimulus(20, 0, 100);

    // Reset with one full frame pending and five samples of the next frame.
    applyStimulus(13, 100, 0);
    applyReset();
    applyStimulus(8, 100, 100);
    applyStimulus(12, 0, 100);

    // Long random traffic, a mid-stream reset, more traffic, then drain.
    applyStimulus(2000, 70, 60);
    applyReset();
    applyStimulus(800, 85, 40);
    applyStimulus(800, 40, 85);
    applyStimulus(40, 0, 100);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
